mult_lane_dispatcher: RTL and testbench
=======================================

// Module: mult_lane_dispatcher
// PURPOSE
// - N-lane AXI-stream switch in front of NUM_LANES polynomial multiplier lanes.
// - Routes whole polynomials (N beats, ended by last) of p and u to lanes in round-robin order.
// - Gathers lane results back onto z in the same polynomial order.
// - Successor to the fixed 2-lane switch: adds parametrised lane count, correct per-lane rdy
//   back-pressure, a registered skid output, length checking and occupancy status.
// PARAMETERS
// - NUM_LANES  4   number of multiplier lanes (>=2)
// - N          16  coefficients per polynomial (beats per packet)
// - QW         64  p / z coefficient width
// - UW         1   u coefficient width
// - LW         $clog2(NUM_LANES)  derived lane-index width
// PORTS
// - clk         in   1              system clock
// - s_rst       in   1              synchronous reset, active high
// - p_data/p_vld/p_last      in  QW/1/1   upstream p stream
// - p_rdy       out  1              p ready
// - u_data/u_vld/u_last      in  UW/1/1   upstream u stream
// - u_rdy       out  1              u ready
// - lp_data/lp_vld/lp_last   out [NUM_LANES][QW]/[NUM_LANES]/[NUM_LANES]  p to lanes
// - lp_rdy      in   [NUM_LANES]    lane p ready
// - lu_data/lu_vld/lu_last   out [NUM_LANES][UW]/[NUM_LANES]/[NUM_LANES]  u to lanes
// - lu_rdy      in   [NUM_LANES]    lane u ready
// - lz_data/lz_vld/lz_last   in  [NUM_LANES][QW]/[NUM_LANES]/[NUM_LANES]  lane results
// - lz_rdy      out  [NUM_LANES]    lane z ready
// - z_data/z_vld/z_last      out QW/1/1   downstream result stream
// - z_rdy       in   1              downstream ready
// - outstanding out  LW+1           polynomials dispatched (p last) but not yet emitted (z last)
// - err_len     out  1              sticky: an input packet's length != N
// BEHAVIOUR
// - Reset (s_rst=1 at clk edge):
//   - sel_p, sel_u, sel_z = 0; beat counters = 0; outstanding = 0; err_len = 0.
//   - Skid buffer empties: z_vld = 0, z_data = 0, z_last = 0.
//   - Reset mid-packet abandons the packet; lanes are not notified (lane reset is the owner's job).
// - Input routing (combinational, zero latency; p and u independent):
//   - lp_vld[i] = p_vld & (sel_p==i); lp_data[i] = p_data for all i; lp_last likewise gated.
//   - p_rdy = lp_rdy[sel_p]. u path is identical using sel_u.
//   - Unselected lanes see vld=0 regardless of their rdy.
// - Selector advance:
//   - On accepted beat (vld&rdy) with last=1, sel_p becomes (sel_p==NUM_LANES-1) ? 0 : sel_p+1.
//   - Same rule for sel_u.
//   - sel_p and sel_u may legally differ transiently; each stream is in order on its own.
// - Length check:
//   - Per stream, a beat counter counts accepted beats and clears on an accepted last.
//   - last on beat index != N-1, or beat index N-1 without last, sets err_len.
//   - Routing is not altered; the selector still advances only on last.
// - Dispatch limit:
//   - When outstanding == NUM_LANES, p_rdy is forced 0 on the first beat of a new p packet.
//   - This prevents overtaking an unread lane. u is not limited.
// - Output gather:
//   - lz_rdy[i] = (sel_z==i) & skid_can_accept; lanes other than sel_z are held off.
//   - The accepted lane beat enters a 2-entry skid buffer.
//   - z_* is driven from the head register: 1-cycle latency.
//   - Full throughput: 1 beat/cycle while z_rdy=1; no beat is dropped or duplicated when z_rdy
//     toggles.
//   - sel_z advances (with wrap) when a beat with lz_last=1 is accepted from lane sel_z.
// - outstanding:
//   - +1 on accepted p last; -1 on z_vld&z_rdy&z_last.
//   - Both in the same cycle: unchanged.
//   - Never exceeds NUM_LANES and never underflows; a z last with outstanding==0 sets err_len.
// TESTING
// - Reset, then 4 packets of N=16 beats on p/u (NUM_LANES=4) -> lanes 0,1,2,3 each get exactly
//   one packet; sel_p wraps to 0.
// - Lanes return results out of order (lane2 first) -> z emits lane0..lane3 results in order;
//   lane2 held with lz_rdy=0 until its turn.
// - Random z_rdy (50%) over 8 packets -> z beat sequence identical to lane outputs; one cycle
//   after lane handshake when z_rdy=1.
// - 5th p packet with no results drained -> p_rdy=0, outstanding=4; one z last accepted ->
//   p_rdy rises next cycle.
// - p packet with last on beat 10 -> err_len=1 from next cycle and stays 1; next packet goes to
//   next lane.
// - s_rst asserted mid-packet on beat 7 -> next cycle all outputs at reset values; new packet
//   routes to lane 0.

Source files
------------

// File: rtl/mult_lane_dispatcher.sv
// Round-robin polynomial switch between p/u sources, NUM_LANES multiplier lanes and the z sink.
module mult_lane_dispatcher #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned N         = 16,
    parameter int unsigned QW        = 64,
    parameter int unsigned UW        = 1,
    localparam int unsigned LW       = $clog2(NUM_LANES)
) (
    input  logic                            clk,
    input  logic                            s_rst,
    input  logic [QW-1:0]                   p_data,
    input  logic                            p_vld,
    input  logic                            p_last,
    output logic                            p_rdy,
    input  logic [UW-1:0]                   u_data,
    input  logic                            u_vld,
    input  logic                            u_last,
    output logic                            u_rdy,
    output logic [NUM_LANES-1:0][QW-1:0]    lp_data,
    output logic [NUM_LANES-1:0]            lp_vld,
    output logic [NUM_LANES-1:0]            lp_last,
    input  logic [NUM_LANES-1:0]            lp_rdy,
    output logic [NUM_LANES-1:0][UW-1:0]    lu_data,
    output logic [NUM_LANES-1:0]            lu_vld,
    output logic [NUM_LANES-1:0]            lu_last,
    input  logic [NUM_LANES-1:0]            lu_rdy,
    input  logic [NUM_LANES-1:0][QW-1:0]    lz_data,
    input  logic [NUM_LANES-1:0]            lz_vld,
    input  logic [NUM_LANES-1:0]            lz_last,
    output logic [NUM_LANES-1:0]            lz_rdy,
    output logic [QW-1:0]                   z_data,
    output logic                            z_vld,
    output logic                            z_last,
    input  logic                            z_rdy,
    output logic [LW:0]                     outstanding,
    output logic                            err_len
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned OW = LW + 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
    localparam logic [OW-1:0] MAX_OUT   = OW'(NUM_LANES);

    logic [LW-1:0] sel_p, sel_u, sel_z;
    logic [CW-1:0] cnt_p, cnt_u;
    logic          p_block;
    logic          p_fire, u_fire, lz_fire, z_fire;
    logic          p_len_bad, u_len_bad;
    logic          o_inc, o_dec, z_under;
    logic          h_vld, t_vld, h_last, t_last;
    logic [QW-1:0] h_data, t_data;
    logic          skid_can_accept;

    assign z_vld  = h_vld;
    assign z_data = h_data;
    assign z_last = h_last;

    // Steer p/u to the selected lane; a blocked p packet start is hidden from the lane as well,
    // so a lane never takes a beat that upstream has not handed over.
    always_comb begin
        lp_data = '0;
        lp_vld  = '0;
        lp_last = '0;
        lu_data = '0;
        lu_vld  = '0;
        lu_last = '0;
        lz_rdy  = '0;
        skid_can_accept = ~t_vld;
        p_block = (cnt_p == '0) && (outstanding == MAX_OUT);
        p_rdy   = lp_rdy[sel_p] & ~p_block;
        u_rdy   = lu_rdy[sel_u];
        for (int i = 0; i < NUM_LANES; i++) begin
            lp_data[i] = p_data;
            lp_vld[i]  = p_vld & ~p_block & (sel_p == LW'(i));
            lp_last[i] = p_last & lp_vld[i];
            lu_data[i] = u_data;
            lu_vld[i]  = u_vld & (sel_u == LW'(i));
            lu_last[i] = u_last & lu_vld[i];
            lz_rdy[i]  = skid_can_accept & (sel_z == LW'(i));
        end
    end

    // Handshake, length-error and occupancy events for this cycle.
    always_comb begin
        p_fire    = p_vld & p_rdy;
        u_fire    = u_vld & u_rdy;
        lz_fire   = lz_vld[sel_z] & skid_can_accept;
        z_fire    = h_vld & z_rdy;
        p_len_bad = p_fire & ((p_last & (cnt_p != LAST_BEAT)) | (~p_last & (cnt_p == LAST_BEAT)));
        u_len_bad = u_fire & ((u_last & (cnt_u != LAST_BEAT)) | (~u_last & (cnt_u == LAST_BEAT)));
        o_inc     = p_fire & p_last;
        o_dec     = z_fire & h_last & (outstanding != '0);
        z_under   = z_fire & h_last & (outstanding == '0);
    end

    // Selectors, beat counters, occupancy and sticky length error.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            sel_p       <= '0;
            sel_u       <= '0;
            sel_z       <= '0;
            cnt_p       <= '0;
            cnt_u       <= '0;
            outstanding <= '0;
            err_len     <= 1'b0;
        end else begin
            if (p_fire) begin
                if (p_last) begin
                    cnt_p <= '0;
                    sel_p <= (sel_p == LAST_LANE) ? '0 : sel_p + LW'(1);
                end else if (cnt_p != LAST_BEAT) begin
                    cnt_p <= cnt_p + CW'(1);
                end
            end
            if (u_fire) begin
                if (u_last) begin
                    cnt_u <= '0;
                    sel_u <= (sel_u == LAST_LANE) ? '0 : sel_u + LW'(1);
                end else if (cnt_u != LAST_BEAT) begin
                    cnt_u <= cnt_u + CW'(1);
                end
            end
            if (lz_fire && lz_last[sel_z]) begin
                sel_z <= (sel_z == LAST_LANE) ? '0 : sel_z + LW'(1);
            end
            if (o_inc && !o_dec && (outstanding != MAX_OUT)) begin
                outstanding <= outstanding + OW'(1);
            end else if (o_dec && !o_inc) begin
                outstanding <= outstanding - OW'(1);
            end
            err_len <= err_len | p_len_bad | u_len_bad | z_under;
        end
    end

    // Two-entry skid: head drives z, tail absorbs one beat while z is stalled.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            h_vld  <= 1'b0;
            h_data <= '0;
            h_last <= 1'b0;
            t_vld  <= 1'b0;
            t_data <= '0;
            t_last <= 1'b0;
        end else if (t_vld) begin
            if (z_fire) begin
                h_data <= t_data;
                h_last <= t_last;
                t_vld  <= 1'b0;
            end
        end else if (h_vld && !z_fire) begin
            if (lz_fire) begin
                t_vld  <= 1'b1;
                t_data <= lz_data[sel_z];
                t_last <= lz_last[sel_z];
            end
        end else begin
            h_vld <= lz_fire;
            if (lz_fire) begin
                h_data <= lz_data[sel_z];
                h_last <= lz_last[sel_z];
            end
        end
    end

endmodule

// File: tb/tb_mult_lane_dispatcher.sv
// Directed bench for mult_lane_dispatcher: routing table, round-robin, gather order, limits, reset.
module tb_mult_lane_dispatcher;

    localparam int unsigned NL = 4;
    localparam int unsigned N  = 16;
    localparam int unsigned QW = 64;
    localparam int unsigned UW = 1;
    localparam int unsigned LW = 2;

    logic                   clk = 1'b0;
    logic                   s_rst;
    logic [QW-1:0]          p_data;
    logic                   p_vld, p_last, p_rdy;
    logic [UW-1:0]          u_data;
    logic                   u_vld, u_last, u_rdy;
    logic [NL-1:0][QW-1:0]  lp_data;
    logic [NL-1:0]          lp_vld, lp_last, lp_rdy;
    logic [NL-1:0][UW-1:0]  lu_data;
    logic [NL-1:0]          lu_vld, lu_last, lu_rdy;
    logic [NL-1:0][QW-1:0]  lz_data;
    logic [NL-1:0]          lz_vld, lz_last, lz_rdy;
    logic [QW-1:0]          z_data;
    logic                   z_vld, z_last, z_rdy;
    logic [LW:0]            outstanding;
    logic                   err_len;

    mult_lane_dispatcher #(.NUM_LANES(NL), .N(N), .QW(QW), .UW(UW)) dut (
        .clk(clk), .s_rst(s_rst),
        .p_data(p_data), .p_vld(p_vld), .p_last(p_last), .p_rdy(p_rdy),
        .u_data(u_data), .u_vld(u_vld), .u_last(u_last), .u_rdy(u_rdy),
        .lp_data(lp_data), .lp_vld(lp_vld), .lp_last(lp_last), .lp_rdy(lp_rdy),
        .lu_data(lu_data), .lu_vld(lu_vld), .lu_last(lu_last), .lu_rdy(lu_rdy),
        .lz_data(lz_data), .lz_vld(lz_vld), .lz_last(lz_last), .lz_rdy(lz_rdy),
        .z_data(z_data), .z_vld(z_vld), .z_last(z_last), .z_rdy(z_rdy),
        .outstanding(outstanding), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int          p_done   = 0;
    logic [63:0] acc_data[$];
    int unsigned acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       p_vld;
        logic       p_last;
        logic [3:0] lp_rdy;
        logic       u_vld;
        logic [3:0] lu_rdy;
        logic [3:0] e_lp_vld;
        logic [3:0] e_lp_last;
        logic       e_p_rdy;
        logic [3:0] e_lu_vld;
        logic       e_u_rdy;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rdata(input int lane, input int seq, input int b);
        return {32'(lane + 1), 16'(seq), 16'(b)};
    endfunction

    task automatic send_p(input int len, input int lane, input logic [63:0] base);
        int bad = 0;
        int t;
        for (int b = 0; b < len; b++) begin
            @(negedge clk);
            p_vld  = 1'b1;
            p_data = base + 64'(b);
            p_last = (b == len - 1);
            #1;
            t = 0;
            while (!p_rdy && t < 2000) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (t >= 2000) begin
                chk("p_rdy_wait", 64'(p_rdy), 64'd1);
                p_vld = 1'b0;
                return;
            end
            if (lp_vld != 4'(1 << lane) || lp_data[lane] !== p_data) bad++;
            @(posedge clk);
        end
        @(negedge clk);
        p_vld  = 1'b0;
        p_last = 1'b0;
        p_done++;
        chk($sformatf("p_pkt_lane%0d", lane), 64'(bad), 64'd0);
    endtask

    task automatic send_u(input int len, input int lane);
        int bad = 0;
        int t;
        for (int b = 0; b < len; b++) begin
            @(negedge clk);
            u_vld  = 1'b1;
            u_data = 1'(b);
            u_last = (b == len - 1);
            #1;
            t = 0;
            while (!u_rdy && t < 2000) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (t >= 2000) begin
                chk("u_rdy_wait", 64'(u_rdy), 64'd1);
                u_vld = 1'b0;
                return;
            end
            if (lu_vld != 4'(1 << lane) || lu_last != (u_last ? 4'(1 << lane) : 4'd0)) bad++;
            @(posedge clk);
        end
        @(negedge clk);
        u_vld  = 1'b0;
        u_last = 1'b0;
        chk($sformatf("u_pkt_lane%0d", lane), 64'(bad), 64'd0);
    endtask

    task automatic lane_send(input int i, input int seq, input int dly);
        int t = 0;
        while (p_done <= seq && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (dly) @(negedge clk);
        for (int b = 0; b < N; b++) begin
            @(negedge clk);
            lz_vld[i]  = 1'b1;
            lz_data[i] = rdata(i, seq, b);
            lz_last[i] = (b == N - 1);
            #1;
            t = 0;
            while (!lz_rdy[i] && t < 5000) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (t >= 5000) begin
                chk("lz_rdy_wait", 64'(lz_rdy[i]), 64'd1);
                lz_vld[i] = 1'b0;
                return;
            end
            acc_data.push_back(lz_data[i]);
            acc_cyc.push_back(cyc);
            @(posedge clk);
        end
        @(negedge clk);
        lz_vld[i]  = 1'b0;
        lz_last[i] = 1'b0;
    endtask

    task automatic collect(input int npkt, input int first_seq, input bit rnd, input bit lat,
                           input bit plim);
        int got = 0, bad_d = 0, bad_l = 0, bad_lat = 0, t = 0;
        int s = first_seq, b = 0;
        bit seen_last = 1'b0, pend = 1'b0;
        logic [63:0] ad;
        int unsigned ac;
        while (got < npkt * int'(N) && t < 20000) begin
            @(negedge clk);
            z_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            t++;
            if (pend) begin
                chk("p_rdy_after_z_last", 64'(p_rdy), 64'd1);
                pend = 1'b0;
            end
            if (z_vld && z_rdy) begin
                if (z_data !== rdata(s % NL, s, b)) bad_d++;
                if (z_last !== (b == N - 1)) bad_l++;
                if (acc_data.size() == 0) begin
                    bad_d++;
                end else begin
                    ad = acc_data.pop_front();
                    ac = acc_cyc.pop_front();
                    if (ad !== z_data) bad_d++;
                    if (lat && (ac + 1 != cyc)) bad_lat++;
                end
                if (plim && z_last && !seen_last) begin
                    chk("p_rdy_before_z_last", 64'(p_rdy), 64'd0);
                    seen_last = 1'b1;
                    pend = 1'b1;
                end
                b++;
                if (b == N) begin
                    b = 0;
                    s++;
                end
                got++;
            end
        end
        if (got < npkt * int'(N)) chk("z_collect_count", 64'(got), 64'(npkt * N));
        chk("z_data_order", 64'(bad_d), 64'd0);
        chk("z_last_pos", 64'(bad_l), 64'd0);
        if (lat) chk("z_latency", 64'(bad_lat), 64'd0);
        z_rdy = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 4'hF, 1'b1, 4'hF, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 4'hE, 1'b0, 4'h1, 4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 4'h1, 1'b1, 4'hE, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0};

        s_rst = 1'b1;
        p_data = '0; p_vld = 1'b0; p_last = 1'b0;
        u_data = '0; u_vld = 1'b0; u_last = 1'b0;
        lp_rdy = 4'hF; lu_rdy = 4'hF;
        lz_data = '0; lz_vld = '0; lz_last = '0;
        z_rdy = 1'b1;
        repeat (3) @(negedge clk);
        s_rst = 1'b0;
        #1;
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err_len", 64'(err_len), 64'd0);
        chk("rst_z_vld", 64'(z_vld), 64'd0);
        chk("rst_z_data", z_data, 64'd0);
        chk("rst_z_last", 64'(z_last), 64'd0);
        chk("rst_lz_rdy", 64'(lz_rdy), 64'h1);
        chk("rst_p_rdy", 64'(p_rdy), 64'd1);

        // Routing table at sel_p = sel_u = 0; inputs dropped before the next rising edge.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            p_vld = vecs[k].p_vld; p_last = vecs[k].p_last; lp_rdy = vecs[k].lp_rdy;
            u_vld = vecs[k].u_vld; lu_rdy = vecs[k].lu_rdy;
            p_data = 64'hA5A5_0000_0000_0000 + 64'(k); u_data = 1'(k);
            #1;
            chk($sformatf("vec%0d_lp_vld", k), 64'(lp_vld), 64'(vecs[k].e_lp_vld));
            chk($sformatf("vec%0d_lp_last", k), 64'(lp_last), 64'(vecs[k].e_lp_last));
            chk($sformatf("vec%0d_p_rdy", k), 64'(p_rdy), 64'(vecs[k].e_p_rdy));
            chk($sformatf("vec%0d_lu_vld", k), 64'(lu_vld), 64'(vecs[k].e_lu_vld));
            chk($sformatf("vec%0d_u_rdy", k), 64'(u_rdy), 64'(vecs[k].e_u_rdy));
            chk($sformatf("vec%0d_lp_data3", k), lp_data[3], 64'hA5A5_0000_0000_0000 + 64'(k));
            #1;
            p_vld = 1'b0; p_last = 1'b0; u_vld = 1'b0;
            lp_rdy = 4'hF; lu_rdy = 4'hF;
        end

        // Four packets fill lanes 0..3.
        fork
            for (int k = 0; k < 4; k++) send_p(N, k, 64'(k) << 32);
            for (int k = 0; k < 4; k++) send_u(N, k);
        join
        @(negedge clk);
        #1;
        chk("full_outstanding", 64'(outstanding), 64'd4);
        chk("full_err_len", 64'(err_len), 64'd0);
        p_vld = 1'b1; u_vld = 1'b1;
        #1;
        chk("full_p_rdy", 64'(p_rdy), 64'd0);
        chk("full_lp_vld", 64'(lp_vld), 64'd0);
        chk("u_wrap_lu_vld", 64'(lu_vld), 64'h1);
        #1;
        p_vld = 1'b0; u_vld = 1'b0;

        // Lanes answer out of order; z must still come out lane 0..3.
        fork
            lane_send(0, 0, 8);
            lane_send(1, 1, 3);
            lane_send(2, 2, 0);
            lane_send(3, 3, 3);
            collect(4, 0, 1'b0, 1'b1, 1'b1);
            begin
                repeat (3) @(negedge clk);
                #2;
                chk("hold_lz_rdy", 64'(lz_rdy), 64'h1);
                chk("hold_lz_vld", 64'(lz_vld), 64'h4);
                chk("hold_z_vld", 64'(z_vld), 64'd0);
            end
        join
        @(negedge clk);
        #1;
        chk("drain_outstanding", 64'(outstanding), 64'd0);

        // Eight more packets with random z back-pressure.
        fork
            for (int k = 0; k < 8; k++) send_p(N, k % NL, 64'(k + 4) << 32);
            for (int k = 0; k < 8; k++) send_u(N, k % NL);
            begin lane_send(0, 4, 2); lane_send(0, 8, 0); end
            begin lane_send(1, 5, 0); lane_send(1, 9, 1); end
            begin lane_send(2, 6, 5); lane_send(2, 10, 0); end
            begin lane_send(3, 7, 1); lane_send(3, 11, 3); end
            collect(8, 4, 1'b1, 1'b0, 1'b0);
        join
        @(negedge clk);
        #1;
        chk("rnd_outstanding", 64'(outstanding), 64'd0);
        chk("rnd_err_len", 64'(err_len), 64'd0);
        chk("rnd_acc_empty", 64'(acc_data.size()), 64'd0);

        // Short packet (last on beat 10): sticky error, selector still advances.
        send_p(11, 0, 64'hE000);
        #1;
        chk("short_err_len", 64'(err_len), 64'd1);
        send_p(N, 1, 64'hF000);
        #1;
        chk("short_err_sticky", 64'(err_len), 64'd1);
        chk("short_outstanding", 64'(outstanding), 64'd2);

        // Park a beat in the skid, then reset in the middle of a p packet on lane 2.
        @(negedge clk);
        z_rdy = 1'b0;
        lz_vld[0] = 1'b1; lz_data[0] = 64'hABCD; lz_last[0] = 1'b0;
        @(negedge clk);
        lz_vld[0] = 1'b0;
        #1;
        chk("pre_rst_z_vld", 64'(z_vld), 64'd1);
        for (int b = 0; b < 7; b++) begin
            @(negedge clk);
            p_vld = 1'b1; p_data = 64'hD000 + 64'(b); p_last = 1'b0;
        end
        @(negedge clk);
        p_data = 64'hD007;
        #1;
        chk("pre_rst_lp_vld", 64'(lp_vld), 64'h4);
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0; p_vld = 1'b0; z_rdy = 1'b1;
        #1;
        chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
        chk("mid_rst_err_len", 64'(err_len), 64'd0);
        chk("mid_rst_z_vld", 64'(z_vld), 64'd0);
        chk("mid_rst_z_data", z_data, 64'd0);
        chk("mid_rst_lz_rdy", 64'(lz_rdy), 64'h1);
        chk("mid_rst_p_rdy", 64'(p_rdy), 64'd1);
        send_p(N, 0, 64'hC000);
        #1;
        chk("post_rst_err_len", 64'(err_len), 64'd0);
        chk("post_rst_outstanding", 64'(outstanding), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
